// File: rtl/noc_tree_down_router_if.sv
// noc_tree_down_router_if: parent-side word input, child-side outputs and
// backpressure for one downward tree router node.
// Optional: NOC_DOWN_DROP_CNT_EN adds per-child overflow drop counters.
interface noc_tree_down_router_if #(
  parameter int unsigned word_width = 16
);
  logic [word_width-1:0] in;
  logic                  busy_1;
  logic                  busy_2;
  logic [word_width-1:0] out_1;
  logic [word_width-1:0] out_2;
  logic                  full;
  logic                  full_1;
  logic                  full_2;
`ifdef NOC_DOWN_DROP_CNT_EN
  logic [7:0]            drop_cnt_1;
  logic [7:0]            drop_cnt_2;

  modport master (
    output in, busy_1, busy_2,
    input  out_1, out_2, full, full_1, full_2, drop_cnt_1, drop_cnt_2
  );

  modport slave (
    input  in, busy_1, busy_2,
    output out_1, out_2, full, full_1, full_2, drop_cnt_1, drop_cnt_2
  );
`else
  modport master (
    output in, busy_1, busy_2,
    input  out_1, out_2, full, full_1, full_2
  );

  modport slave (
    input  in, busy_1, busy_2,
    output out_1, out_2, full, full_1, full_2
  );
`endif
endinterface

// File: rtl/noc_tree_down_router.sv
// noc_tree_down_router: routes each valid parent word to one of two child
// ports by a payload routing bit; each child has a FIFO and a registered,
// busy-aware output stage. Channels are fully independent.
// Optional: define NOC_DOWN_DROP_CNT_EN for saturating 8-bit overflow drop
// counters drop_cnt_1 / drop_cnt_2.
module noc_tree_down_router #(
  parameter int unsigned word_width     = 16,
  parameter int unsigned val_bit        = 1,
  parameter int unsigned log_buffer_len = 3,
  parameter int unsigned route_bit      = 0
) (
  input logic                   clk,
  input logic                   rst,
  noc_tree_down_router_if.slave bus
);

  localparam int unsigned PW    = word_width - val_bit;
  localparam int unsigned AW    = log_buffer_len;
  localparam int unsigned CW    = log_buffer_len + 1;
  localparam int unsigned DEPTH = 1 << log_buffer_len;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  localparam logic [val_bit-1:0] VAL_ONES = '1;

  logic                  in_valid;
  logic                  in_route;
  logic [PW-1:0]         in_payload;
  logic [1:0]            busy;
  logic [word_width-1:0] out_w [2];
  logic [1:0]            full_w;

  assign in_valid   = bus.in[word_width-1];
  assign in_payload = bus.in[PW-1:0];
  assign in_route   = in_payload[route_bit];
  assign busy[0]    = bus.busy_1;
  assign busy[1]    = bus.busy_2;

  assign bus.out_1  = out_w[0];
  assign bus.out_2  = out_w[1];
  assign bus.full_1 = full_w[0];
  assign bus.full_2 = full_w[1];
  assign bus.full   = full_w[0] | full_w[1];

`ifdef NOC_DOWN_DROP_CNT_EN
  logic [7:0] drop_cnt_w [2];
  assign bus.drop_cnt_1 = drop_cnt_w[0];
  assign bus.drop_cnt_2 = drop_cnt_w[1];
`endif

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [PW-1:0]         mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [word_width-1:0] out_q;
    logic [word_width-1:0] out_nxt;
    logic                  push_req;
    logic                  push_ok;
    logic                  pop;
    logic                  empty;
    logic                  at_cap;

    assign push_req = in_valid && (in_route == 1'(ch));
    assign empty    = (count == '0);
    assign at_cap   = (count == CW'(DEPTH));
    // A full FIFO still accepts a push when a pop frees a slot the same cycle.
    assign push_ok  = push_req && (!at_cap || pop);

    assign full_w[ch] = (count >= CW'(DEPTH - 1));
    assign out_w[ch]  = out_q;

    // Channel FSM: decides pop and next output word.
    always_comb begin
      state_nxt = state;
      out_nxt   = out_q;
      pop       = 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            pop       = 1'b1;
            out_nxt   = {VAL_ONES, mem[rd_ptr]};
            state_nxt = SEND;
          end
        end
        SEND, STALL: begin
          if (busy[ch]) begin
            state_nxt = STALL;
          end else if (!empty) begin
            pop       = 1'b1;
            out_nxt   = {VAL_ONES, mem[rd_ptr]};
            state_nxt = SEND;
          end else begin
            out_nxt   = '0;
            state_nxt = IDLE;
          end
        end
        default: begin
          out_nxt   = '0;
          state_nxt = IDLE;
        end
      endcase
    end

    // FSM state and registered output word.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        out_q <= '0;
      end else begin
        state <= state_nxt;
        out_q <= out_nxt;
      end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
        if (push_ok && !pop)      count <= count + CW'(1);
        else if (!push_ok && pop) count <= count - CW'(1);
      end
    end

    // FIFO payload storage; validity is regenerated at the output.
    always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= in_payload;
    end

`ifdef NOC_DOWN_DROP_CNT_EN
    logic [7:0] drop_cnt;

    // Saturating count of pushes lost to overflow.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        drop_cnt <= '0;
      end else if (push_req && !push_ok && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end

    assign drop_cnt_w[ch] = drop_cnt;
`endif
  end

endmodule

// File: tb/tb_noc_tree_down_router.sv
// tb_noc_tree_down_router: scoreboard bench for the two-child down router.
module tb_noc_tree_down_router;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] exp_q1 [$];
  logic [15:0] exp_q2 [$];
  logic [15:0] mon_e1;
  logic [15:0] mon_e2;

  noc_tree_down_router_if #(.word_width(16)) bus ();

  noc_tree_down_router #(
    .word_width(16), .val_bit(1), .log_buffer_len(3), .route_bit(0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard: a transfer is a valid output with busy low at the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_1[15] && !bus.busy_1) begin
        checks++;
        if (exp_q1.size() == 0) begin
          errors++;
          $display("FAIL sb_out_1 got %h want (none)", bus.out_1);
        end else begin
          mon_e1 = exp_q1.pop_front();
          if (bus.out_1 !== mon_e1) begin
            errors++;
            $display("FAIL sb_out_1 got %h want %h", bus.out_1, mon_e1);
          end
        end
      end
      if (bus.out_2[15] && !bus.busy_2) begin
        checks++;
        if (exp_q2.size() == 0) begin
          errors++;
          $display("FAIL sb_out_2 got %h want (none)", bus.out_2);
        end else begin
          mon_e2 = exp_q2.pop_front();
          if (bus.out_2 !== mon_e2) begin
            errors++;
            $display("FAIL sb_out_2 got %h want %h", bus.out_2, mon_e2);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one word for one cycle; kept words are queued for their child.
  task automatic send(input logic [15:0] w, input bit kept);
    bus.in = w;
    if (kept && w[15]) begin
      if (w[0]) exp_q2.push_back(w);
      else      exp_q1.push_back(w);
    end
    step();
    bus.in = '0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q1.size() != 0 || exp_q2.size() != 0 ||
            bus.out_1[15] || bus.out_2[15]) && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL drain got q1=%0d q2=%0d left want 0", exp_q1.size(), exp_q2.size());
    end
  endtask

  task automatic test_reset();
    bus.in = '0; bus.busy_1 = 1'b0; bus.busy_2 = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({bus.out_1, bus.out_2} !== 32'h0) begin
      errors++; $display("FAIL reset_out got %h want 0", {bus.out_1, bus.out_2});
    end
    checks++;
    if ({bus.full, bus.full_1, bus.full_2} !== 3'b000) begin
      errors++; $display("FAIL reset_full got %b want 000", {bus.full, bus.full_1, bus.full_2});
    end
`ifdef NOC_DOWN_DROP_CNT_EN
    checks++;
    if ({bus.drop_cnt_1, bus.drop_cnt_2} !== 16'h0) begin
      errors++; $display("FAIL reset_drop got %h want 0", {bus.drop_cnt_1, bus.drop_cnt_2});
    end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_routing();
    send(16'h8002, 1'b1);
    checks++;
    if (bus.out_1 !== 16'h0000) begin
      errors++; $display("FAIL route_latency got %h want 0000", bus.out_1);
    end
    step();
    checks++;
    if (bus.out_1 !== 16'h8002) begin
      errors++; $display("FAIL route_left got %h want 8002", bus.out_1);
    end
    checks++;
    if (bus.out_2[15] !== 1'b0) begin
      errors++; $display("FAIL route_left_other got %b want 0", bus.out_2[15]);
    end
    step();
    send(16'h8005, 1'b1);
    step();
    checks++;
    if (bus.out_2 !== 16'h8005) begin
      errors++; $display("FAIL route_right got %h want 8005", bus.out_2);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    bus.busy_1 = 1'b1;
    send(16'h8010, 1'b1);
    send(16'h8012, 1'b1);
    checks++;
    if (bus.out_1 !== 16'h8010) begin
      errors++; $display("FAIL bp_load got %h want 8010", bus.out_1);
    end
    step(); step();
    checks++;
    if (bus.out_1 !== 16'h8010) begin
      errors++; $display("FAIL bp_hold got %h want 8010", bus.out_1);
    end
    bus.busy_1 = 1'b0;
    step();
    bus.busy_1 = 1'b1;
    checks++;
    if (bus.out_1 !== 16'h8012) begin
      errors++; $display("FAIL bp_next got %h want 8012", bus.out_1);
    end
    step();
    checks++;
    if (bus.out_1 !== 16'h8012) begin
      errors++; $display("FAIL bp_hold2 got %h want 8012", bus.out_1);
    end
    bus.busy_1 = 1'b0;
    wait_drain();
  endtask

  task automatic test_full_overflow();
    bus.busy_1 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(16'h8000 + 16'(2 * i), 1'b1);
      checks++;
      if ({bus.full, bus.full_1, bus.full_2} !== {(i >= 7), (i >= 7), 1'b0}) begin
        errors++;
        $display("FAIL full_fill[%0d] got %b want %b", i,
                 {bus.full, bus.full_1, bus.full_2}, {(i >= 7), (i >= 7), 1'b0});
      end
    end
    checks++;
    if (bus.out_1 !== 16'h8000) begin
      errors++; $display("FAIL full_head got %h want 8000", bus.out_1);
    end
    send(16'h8014, 1'b0);
    checks++;
    if (bus.full_1 !== 1'b1) begin
      errors++; $display("FAIL drop_full got %b want 1", bus.full_1);
    end
`ifdef NOC_DOWN_DROP_CNT_EN
    checks++;
    if (bus.drop_cnt_1 !== 8'd1) begin
      errors++; $display("FAIL drop_cnt_1 got %0d want 1", bus.drop_cnt_1);
    end
`endif
    bus.busy_1 = 1'b0;
    wait_drain();
    checks++;
    if (bus.full !== 1'b0) begin
      errors++; $display("FAIL full_clear got %b want 0", bus.full);
    end
  endtask

  task automatic test_simul_push_pop();
    bus.busy_1 = 1'b1;
    for (int i = 0; i < 9; i++) send(16'h8040 + 16'(2 * i), 1'b1);
    bus.busy_1 = 1'b0;
    send(16'h8060, 1'b1);
    bus.busy_1 = 1'b1;
    checks++;
    if (bus.out_1 !== 16'h8042) begin
      errors++; $display("FAIL pp_next got %h want 8042", bus.out_1);
    end
    checks++;
    if (bus.full_1 !== 1'b1) begin
      errors++; $display("FAIL pp_full got %b want 1", bus.full_1);
    end
`ifdef NOC_DOWN_DROP_CNT_EN
    checks++;
    if (bus.drop_cnt_1 !== 8'd1) begin
      errors++; $display("FAIL pp_drop_cnt got %0d want 1", bus.drop_cnt_1);
    end
`endif
    bus.busy_1 = 1'b0;
    wait_drain();
  endtask

  task automatic test_independence();
    int n = 0;
    bus.busy_1 = 1'b1;
    send(16'h8020, 1'b1);
    send(16'h8021, 1'b1);
    send(16'h8022, 1'b1);
    send(16'h8023, 1'b1);
    while (exp_q2.size() != 0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (exp_q2.size() != 0) begin
      errors++; $display("FAIL indep_right got %0d pending want 0", exp_q2.size());
    end
    checks++;
    if (bus.out_1 !== 16'h8020) begin
      errors++; $display("FAIL indep_left_hold got %h want 8020", bus.out_1);
    end
    bus.busy_1 = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_midstream();
    bus.busy_2 = 1'b1;
    for (int i = 0; i < 9; i++) send(16'h8001 + 16'(2 * i), 1'b1);
    checks++;
    if ({bus.full, bus.out_2} !== {1'b1, 16'h8001}) begin
      errors++; $display("FAIL mid_prefill got %h want 18001", {bus.full, bus.out_2});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_2 !== 16'h0000) begin
      errors++; $display("FAIL mid_rst_out got %h want 0000", bus.out_2);
    end
    checks++;
    if ({bus.full, bus.full_2} !== 2'b00) begin
      errors++; $display("FAIL mid_rst_full got %b want 00", {bus.full, bus.full_2});
    end
    exp_q1.delete();
    exp_q2.delete();
    step();
    rst = 1'b0;
    bus.busy_2 = 1'b0;
    send(16'h8007, 1'b1);
    step();
    checks++;
    if (bus.out_2 !== 16'h8007) begin
      errors++; $display("FAIL mid_resume got %h want 8007", bus.out_2);
    end
    wait_drain();
  endtask

  initial begin
    bus.in = '0;
    bus.busy_1 = 1'b0;
    bus.busy_2 = 1'b0;
    test_reset();
    test_routing();
    test_backpressure();
    test_full_overflow();
    test_simul_push_pop();
    test_independence();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
